// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
//   Two-port round-robin arbiter and sequencer in front of the single-port
//   1024x32 data memory (dm). Port 0 is the CPU load/store path, port 1 the
//   secondary master (loader/debug/DMA). One owner holds dm at a time; a locked
//   owner may keep it for a burst, capped at MAX_BURST beats whenever the other
//   port is waiting. Read data comes back registered with a one-cycle valid.
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous active-low reset (0 = reset)
//   m0_req / m1_req     access request, held until the beat is accepted
//   mX_we               1 = store, 0 = load
//   mX_lock             keep ownership for following beats
//   mX_addr, mX_wdata   word address / store data
//   mX_gnt              port owns dm this cycle (beat = mX_req & mX_gnt)
//   mX_rvalid, mX_rdata load data, valid one cycle after the load beat
//   mem_addr, mem_wdata, mem_we  to dm
//   mem_rdata           from dm (combinational read)
// -----------------------------------------------------------------------------
module dm_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  // port 0
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  // port 1
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  // data memory
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Counter wide enough for 0..MAX_BURST-1; a MAX_BURST of 1 still needs one bit.
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             rr_next, rr_nxt;     // port that wins the next tie from IDLE
  logic [CNT_W-1:0] beat_cnt, cnt_nxt;   // beats taken since entering the OWN state

  logic beat0, beat1;
  logic at_cap;

  // Grants are Moore outputs of the state register only.
  assign m0_gnt = (state == OWN0);
  assign m1_gnt = (state == OWN1);
  assign beat0  = m0_gnt & m0_req;
  assign beat1  = m1_gnt & m1_req;
  assign at_cap = (beat_cnt == CNT_MAX);

  // Memory-side mux: only the owner's inputs reach dm; zero while IDLE, so the
  // bus moves only at clock edges (state change) or with the owner's inputs.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a path
    // that leaves one unassigned infers a latch.
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    unique case (state)
      OWN0: begin
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
        mem_we    = m0_req & m0_we;
      end
      OWN1: begin
        mem_addr  = m1_addr;
        mem_wdata = m1_wdata;
        mem_we    = m1_req & m1_we;
      end
      default: ;
    endcase
  end

  // Next-state, burst counter and round-robin pointer.
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_next;
    cnt_nxt   = beat_cnt;

    unique case (state)
      IDLE: begin
        if (m0_req && m1_req) state_nxt = rr_next ? OWN1 : OWN0;
        else if (m0_req)      state_nxt = OWN0;
        else if (m1_req)      state_nxt = OWN1;
      end
      OWN0: begin
        // Owner gone: hand straight over (no IDLE bubble) or drop to IDLE.
        // Owner beating: yield to a waiting port unless locked below the cap.
        if (!m0_req)                           state_nxt = m1_req ? OWN1 : IDLE;
        else if (m1_req && (!m0_lock || at_cap)) state_nxt = OWN1;
      end
      OWN1: begin
        if (!m1_req)                           state_nxt = m0_req ? OWN0 : IDLE;
        else if (m0_req && (!m1_lock || at_cap)) state_nxt = OWN0;
      end
      default: state_nxt = IDLE;
    endcase

    if ((state_nxt != state) && (state_nxt != IDLE)) begin
      // Fresh ownership: restart the burst count; the other port wins the next tie.
      cnt_nxt = '0;
      rr_nxt  = (state_nxt == OWN0);
    end else if ((beat0 || beat1) && !at_cap) begin
      cnt_nxt = beat_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rr_next  <= 1'b0;
      beat_cnt <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state    <= state_nxt;
      rr_next  <= rr_nxt;
      beat_cnt <= cnt_nxt;
    end
  end

  // Load return path: capture dm read data on the load beat; rdata holds
  // between loads, rvalid is a single-cycle pulse per load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= beat0 & ~m0_we;
      m1_rvalid <= beat1 & ~m1_we;
      if (beat0 && !m0_we) m0_rdata <= mem_rdata;
      if (beat1 && !m1_we) m1_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_arbiter
//   Bench for dm_arbiter (MAX_BURST = 4) with a behavioural 1024x32 dm.
//   Each port is fed from an operation queue (request held until its beat);
//   expected load data comes from a bench-side reference memory and is pushed
//   to a per-port scoreboard at the beat, then popped when rvalid appears.
//   Expected grant sequences are written out per scenario.
// -----------------------------------------------------------------------------
module tb_dm_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              clk;
  logic              reset;
  logic              m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata, m0_rdata;
  logic              m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata, m1_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_we;

  dm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_lock   (m0_lock),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_lock   (m1_lock),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- dm model
  function automatic logic [31:0] pat(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  logic [31:0] dm [1024];
  logic        dm_ready = 1'b0;
  logic [31:0] ref_mem [1024];

  assign mem_rdata = dm[mem_addr];

  always @(posedge clk) begin
    if (!dm_ready) begin
      for (int i = 0; i < 1024; i++) dm[i] <= pat(i);
      dm_ready <= 1'b1;
    end else if (mem_we) begin
      dm[mem_addr] <= mem_wdata;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ------------------------------------------------------------ bookkeeping
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic              we;
    logic              lock;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } op_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } rd_t;

  op_t        q0[$], q1[$];
  rd_t        sb0[$], sb1[$];
  logic [1:0] exp_g[$];   // per cycle: 0 none, 1 port0, 2 port1

  function automatic op_t mk(input logic we, input logic lock, input int addr,
                             input logic [31:0] wdata);
    op_t o;
    o.we    = we;
    o.lock  = lock;
    o.addr  = ADDR_W'(addr);
    o.wdata = wdata;
    return o;
  endfunction

  task automatic drive();
    if (q0.size() > 0) begin
      m0_req = 1'b1; m0_we = q0[0].we; m0_lock = q0[0].lock;
      m0_addr = q0[0].addr; m0_wdata = q0[0].wdata;
    end else begin
      m0_req = 1'b0; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = '0; m0_wdata = '0;
    end
    if (q1.size() > 0) begin
      m1_req = 1'b1; m1_we = q1[0].we; m1_lock = q1[0].lock;
      m1_addr = q1[0].addr; m1_wdata = q1[0].wdata;
    end else begin
      m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = '0; m1_wdata = '0;
    end
  endtask

  // One clock cycle: drive at posedge+1, sample at negedge, scoreboard beats.
  task automatic cycle();
    op_t        op;
    logic       exp_we;
    logic [1:0] g;
    drive();
    @(negedge clk);
    exp_we = 1'b0;
    if (exp_g.size() > 0) begin
      g = exp_g.pop_front();
      check("gnt", 32'({m1_gnt, m0_gnt}), 32'(g));
    end
    if (m0_req && m0_gnt) begin
      op = q0.pop_front();
      check("addr0", 32'(mem_addr), 32'(op.addr));
      if (op.we) begin
        exp_we = 1'b1;
        check("wdata0", mem_wdata, op.wdata);
        ref_mem[op.addr] = op.wdata;
      end else begin
        sb0.push_back('{ref_mem[op.addr], cyc + 1});
      end
    end
    if (m1_req && m1_gnt) begin
      op = q1.pop_front();
      check("addr1", 32'(mem_addr), 32'(op.addr));
      if (op.we) begin
        exp_we = 1'b1;
        check("wdata1", mem_wdata, op.wdata);
        ref_mem[op.addr] = op.wdata;
      end else begin
        sb1.push_back('{ref_mem[op.addr], cyc + 1});
      end
    end
    check("mem_we", 32'(mem_we), 32'(exp_we));
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic apply_reset();
    q0.delete(); q1.delete(); exp_g.delete(); sb0.delete(); sb1.delete();
    drive();
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic drained(input string tag);
    check({tag, "_q0"},  32'(q0.size()),  32'd0);
    check({tag, "_q1"},  32'(q1.size()),  32'd0);
    check({tag, "_sb0"}, 32'(sb0.size()), 32'd0);
    check({tag, "_sb1"}, 32'(sb1.size()), 32'd0);
  endtask

  // ------------------------------------------------------ read-data monitor
  always @(negedge clk) begin
    rd_t e;
    if (m0_rvalid) begin
      if (sb0.size() == 0) check("rvalid0_spurious", 32'd1, 32'd0);
      else begin
        e = sb0.pop_front();
        check("rvalid0_lag", 32'(cyc), 32'(e.due));
        check("rdata0", m0_rdata, e.data);
      end
    end else if (sb0.size() > 0 && sb0[0].due <= cyc) begin
      check("rvalid0_missing", 32'd0, 32'd1);
      void'(sb0.pop_front());
    end
    if (m1_rvalid) begin
      if (sb1.size() == 0) check("rvalid1_spurious", 32'd1, 32'd0);
      else begin
        e = sb1.pop_front();
        check("rvalid1_lag", 32'(cyc), 32'(e.due));
        check("rdata1", m1_rdata, e.data);
      end
    end else if (sb1.size() > 0 && sb1[0].due <= cyc) begin
      check("rvalid1_missing", 32'd0, 32'd1);
      void'(sb1.pop_front());
    end
  end

  // -------------------------------------------------------------- scenarios
  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);

    // 1: reset held with a pending request, then release.
    reset = 1'b0;
    q0.push_back(mk(1'b0, 1'b0, 1, 32'h0));
    drive();
    #12;
    check("rst_gnt",    32'({m1_gnt, m0_gnt}),       32'd0);
    check("rst_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
    check("rst_we",     32'(mem_we),                 32'd0);
    check("rst_addr",   32'(mem_addr),               32'd0);
    check("rst_wdata",  mem_wdata,                   32'd0);
    check("rst_rdata0", m0_rdata,                    32'd0);
    check("rst_rdata1", m1_rdata,                    32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_g = '{2'd0, 2'd1, 2'd1, 2'd0};
    run(5);
    check("t1_rdata1_hold", m1_rdata, 32'd0);
    drained("t1");

    // 2: store 0xDEADBEEF to addr 5, load it back.
    q0.push_back(mk(1'b1, 1'b0, 5, 32'hDEAD_BEEF));
    q0.push_back(mk(1'b0, 1'b0, 5, 32'h0));
    exp_g = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
    run(6);
    check("t2_rdata_hold", m0_rdata, 32'hDEAD_BEEF);
    check("t2_dm5", dm[5], 32'hDEAD_BEEF);
    drained("t2");

    // 3: both ports continuous, unlocked, from IDLE after reset: 0,1,0,1...
    apply_reset();
    q0.push_back(mk(1'b1, 1'b0, 10, 32'h1111_0010));
    q0.push_back(mk(1'b0, 1'b0, 10, 32'h0));
    q0.push_back(mk(1'b1, 1'b0, 11, 32'h1111_0011));
    q0.push_back(mk(1'b0, 1'b0, 20, 32'h0));
    q1.push_back(mk(1'b0, 1'b0, 20, 32'h0));
    q1.push_back(mk(1'b1, 1'b0, 20, 32'h2222_0020));
    q1.push_back(mk(1'b0, 1'b0, 11, 32'h0));
    q1.push_back(mk(1'b0, 1'b0, 21, 32'h0));
    exp_g = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd0};
    run(12);
    drained("t3");

    // 4: port 0 locked burst of 8 loads vs waiting port 1; cap of 4 beats.
    apply_reset();
    for (int i = 0; i < 8; i++) q0.push_back(mk(1'b0, 1'b1, 100 + i, 32'h0));
    q1.push_back(mk(1'b0, 1'b0, 200, 32'h0));
    q1.push_back(mk(1'b0, 1'b0, 201, 32'h0));
    exp_g = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2,
              2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0};
    run(14);
    drained("t4");

    // 5: port 1 alone, three unlocked loads, then park and go idle.
    for (int i = 0; i < 3; i++) q1.push_back(mk(1'b0, 1'b0, 300 + i, 32'h0));
    exp_g = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
    run(7);
    drained("t5");

    // 6: reset in the middle of a locked store burst.
    for (int i = 0; i < 4; i++) q0.push_back(mk(1'b1, 1'b1, 400 + i, 32'hC0DE_0000 + 32'(i)));
    exp_g = '{2'd0, 2'd1, 2'd1};
    run(3);
    drive();
    @(negedge clk);
    check("t6_pre_gnt",  32'(m0_gnt),   32'd1);
    check("t6_pre_we",   32'(mem_we),   32'd1);
    check("t6_pre_addr", 32'(mem_addr), 32'd402);
    #2;
    reset = 1'b0;
    #1;
    check("t6_abort_we",   32'(mem_we),              32'd0);
    check("t6_abort_gnt",  32'({m1_gnt, m0_gnt}),    32'd0);
    check("t6_abort_addr", 32'(mem_addr),            32'd0);
    @(posedge clk);
    #1;
    q0.delete();
    drive();
    check("t6_dm400", dm[400], 32'hC0DE_0000);
    check("t6_dm401", dm[401], 32'hC0DE_0001);
    check("t6_dm402", dm[402], ref_mem[402]);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_g = '{2'd0, 2'd0};
    run(2);
    drained("t6");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
